// File: rtl/display_pontos_anim.sv
// Score display driver: sequential double-dabble conversion of a W-bit score into
// DIGITS seven-segment displays, with count-up animation, blink and zero blanking.

module hexa7seg (
  input  logic [3:0] codigo,
  output logic [6:0] segmentos
);
  logic [6:0] seg_on;

  // Segments are active-low on the board; seg_on is gfedcba with 1 = lit.
  always_comb begin
    seg_on = 7'b0000000;
    case (codigo)
      4'd0: seg_on = 7'b0111111;
      4'd1: seg_on = 7'b0000110;
      4'd2: seg_on = 7'b1011011;
      4'd3: seg_on = 7'b1001111;
      4'd4: seg_on = 7'b1100110;
      4'd5: seg_on = 7'b1101101;
      4'd6: seg_on = 7'b1111101;
      4'd7: seg_on = 7'b0000111;
      4'd8: seg_on = 7'b1111111;
      4'd9: seg_on = 7'b1101111;
      default: seg_on = 7'b0000000;
    endcase
    segmentos = ~seg_on;
  end
endmodule

module display_pontos_anim #(
  parameter int W             = 7,
  parameter int DIGITS        = 3,
  parameter int SUPRIME_ZEROS = 1,
  parameter int STEP_DIV      = 1_000_000,
  parameter int BLINK_DIV     = 25_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [W-1:0]          pontos,
  input  logic                  enable,
  input  logic                  animar,
  input  logic                  piscar,
  output logic [7*DIGITS-1:0]   disp,
  output logic [4*DIGITS-1:0]   digitos_bcd,
  output logic                  ocupado,
  output logic                  atualizado
);
  // The accumulator always keeps at least one digit above the displayed ones, so
  // overflow is simply "any upper digit non-zero" and the add-3 stage never wraps.
  localparam int NEED_DIG = (W * 30103) / 100000 + 1;
  localparam int ACC_DIG  = (NEED_DIG > DIGITS) ? NEED_DIG : DIGITS + 1;
  localparam int STEP_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int BLINK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BIT_W    = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {OCIOSO, CONVERTE, CARREGA} estado_t;

  estado_t               estado_q, estado_d;
  logic [W-1:0]          mostrado_q, mostrado_d;
  logic [W-1:0]          convertido_q, convertido_d;
  logic [W-1:0]          captura_q, captura_d;
  logic [W-1:0]          shift_q, shift_d;
  logic [4*ACC_DIG-1:0]  acc_q, acc_d, acc_adj;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [4*DIGITS-1:0]   digitos_q, digitos_d;
  logic                  atualizado_q, atualizado_d;
  logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  fase_q, fase_d;
  logic                  step_wrap, blink_wrap, overflow;
  logic [DIGITS-1:0]     zeros_acima;
  logic [3:0]            codigo [DIGITS];

  always_comb begin
    step_wrap   = (step_cnt_q == STEP_W'(STEP_DIV - 1));
    step_cnt_d  = step_wrap ? '0 : step_cnt_q + STEP_W'(1);
    blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
    fase_d      = fase_q ^ blink_wrap;

    mostrado_d = mostrado_q;
    if (!animar || (pontos < mostrado_q))
      mostrado_d = pontos;
    else if ((pontos > mostrado_q) && step_wrap)
      mostrado_d = mostrado_q + W'(1);
  end

  for (genvar gi = 0; gi < ACC_DIG; gi++) begin : g_add3
    assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                           : acc_q[4*gi +: 4];
  end

  assign overflow = |acc_q[4*ACC_DIG-1:4*DIGITS];

  always_comb begin
    estado_d     = estado_q;
    convertido_d = convertido_q;
    captura_d    = captura_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    digitos_d    = digitos_q;
    atualizado_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (mostrado_q != convertido_q) begin
          captura_d = mostrado_q;
          shift_d   = mostrado_q;
          acc_d     = '0;
          bit_cnt_d = '0;
          estado_d  = CONVERTE;
        end
      end
      CONVERTE: begin
        acc_d     = {acc_adj[4*ACC_DIG-2:0], shift_q[W-1]};
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(W - 1))
          estado_d = CARREGA;
      end
      CARREGA: begin
        digitos_d    = overflow ? {DIGITS{4'd9}} : acc_q[4*DIGITS-1:0];
        convertido_d = captura_q;
        atualizado_d = 1'b1;
        estado_d     = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      mostrado_q   <= '0;
      convertido_q <= '0;
      captura_q    <= '0;
      shift_q      <= '0;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      digitos_q    <= '0;
      atualizado_q <= 1'b0;
      step_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      fase_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      mostrado_q   <= mostrado_d;
      convertido_q <= convertido_d;
      captura_q    <= captura_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      digitos_q    <= digitos_d;
      atualizado_q <= atualizado_d;
      step_cnt_q   <= step_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      fase_q       <= fase_d;
    end
  end

  // zeros_acima[i]: digit i and every digit above it are zero.
  always_comb begin
    zeros_acima = '0;
    zeros_acima[DIGITS-1] = (digitos_q[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--)
      zeros_acima[i] = zeros_acima[i+1] && (digitos_q[4*i +: 4] == 4'd0);
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_disp
    assign codigo[gi] = !enable                ? 4'd10 :
                        (piscar && fase_q)     ? 4'd10 :
                        ((SUPRIME_ZEROS != 0) && (gi != 0) && zeros_acima[gi]) ? 4'd10 :
                        digitos_q[4*gi +: 4];
    hexa7seg u_dec (
      .codigo    (codigo[gi]),
      .segmentos (disp[7*gi +: 7])
    );
  end

  assign digitos_bcd = digitos_q;
  assign ocupado     = (estado_q != OCIOSO);
  assign atualizado  = atualizado_q;

endmodule

// File: tb/tb_display_pontos_anim.sv
// Bench for display_pontos_anim: three instances (W=7 with and without zero
// blanking, W=10) checked every cycle against a latency-level behavioural model.

module tb_display_pontos_anim;
  localparam int STEP  = 4;
  localparam int BLINK = 5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, animar, piscar;
  logic [6:0]  pontos7;
  logic [9:0]  pontos10;
  logic [20:0] disp_x [3];
  logic [11:0] bcd_x [3];
  logic [2:0]  ocup_x, atu_x;

  display_pontos_anim #(.W(7), .DIGITS(3), .SUPRIME_ZEROS(1), .STEP_DIV(STEP), .BLINK_DIV(BLINK)) dut_a (
    .clock(clk), .reset(reset), .pontos(pontos7), .enable(enable), .animar(animar), .piscar(piscar),
    .disp(disp_x[0]), .digitos_bcd(bcd_x[0]), .ocupado(ocup_x[0]), .atualizado(atu_x[0]));

  display_pontos_anim #(.W(7), .DIGITS(3), .SUPRIME_ZEROS(0), .STEP_DIV(STEP), .BLINK_DIV(BLINK)) dut_b (
    .clock(clk), .reset(reset), .pontos(pontos7), .enable(enable), .animar(animar), .piscar(piscar),
    .disp(disp_x[1]), .digitos_bcd(bcd_x[1]), .ocupado(ocup_x[1]), .atualizado(atu_x[1]));

  display_pontos_anim #(.W(10), .DIGITS(3), .SUPRIME_ZEROS(1), .STEP_DIV(STEP), .BLINK_DIV(BLINK)) dut_c (
    .clock(clk), .reset(reset), .pontos(pontos10), .enable(enable), .animar(animar), .piscar(piscar),
    .disp(disp_x[2]), .digitos_bcd(bcd_x[2]), .ocupado(ocup_x[2]), .atualizado(atu_x[2]));

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic int to_bcd(input int v);
    return (v % 10) | (((v / 10) % 10) << 4) | (((v / 100) % 10) << 8);
  endfunction

  // Model state: value shown, last converted value, pending conversion countdown.
  int m_most [3], m_conv [3], m_cap [3], m_left [3], m_dig [3];
  bit m_upd [3];
  int m_step, m_bcnt;
  bit m_phase;
  int wid [3] = '{7, 7, 10};
  bit sup [3] = '{1'b1, 1'b0, 1'b1};

  function automatic logic [20:0] exp_disp(input int v, input bit s);
    logic [20:0] r;
    int pw;
    r  = '0;
    pw = 1;
    for (int d = 0; d < 3; d++) begin
      if (!enable || (piscar && m_phase) || (s && d > 0 && v < pw))
        r[7*d +: 7] = 7'h7F;
      else
        r[7*d +: 7] = seg((v / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    int p, nm;
    bit wrap;
    wrap = (m_step == STEP - 1);
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_most[k] = 0; m_conv[k] = 0; m_cap[k] = 0; m_left[k] = 0; m_dig[k] = 0; m_upd[k] = 0;
      end
      m_step = 0; m_bcnt = 0; m_phase = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        p  = (k == 2) ? int'(pontos10) : int'(pontos7);
        nm = m_most[k];
        if (!animar || p < m_most[k]) nm = p;
        else if (p > m_most[k] && wrap) nm = m_most[k] + 1;
        m_upd[k] = 0;
        if (m_left[k] == 0) begin
          if (m_most[k] != m_conv[k]) begin
            m_cap[k]  = m_most[k];
            m_left[k] = wid[k] + 1;
          end
        end else begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_dig[k]  = (m_cap[k] > 999) ? 999 : m_cap[k];
            m_conv[k] = m_cap[k];
            m_upd[k]  = 1;
          end
        end
        m_most[k] = nm;
      end
      m_step = wrap ? 0 : m_step + 1;
      if (m_bcnt == BLINK - 1) begin m_bcnt = 0; m_phase = !m_phase; end
      else m_bcnt++;
    end
  end

  always @(negedge clk) begin : compare
    int ma;
    if (cmp_on) begin
      for (int k = 0; k < 3; k++) begin
        ma = (k == 0) ? int'(dut_a.mostrado_q) : (k == 1) ? int'(dut_b.mostrado_q) : int'(dut_c.mostrado_q);
        chk("mostrado", k, ma, m_most[k]);
        chk("digitos_bcd", k, bcd_x[k], to_bcd(m_dig[k]));
        chk("ocupado", k, ocup_x[k], m_left[k] != 0);
        chk("atualizado", k, atu_x[k], m_upd[k]);
        chk("disp", k, disp_x[k], exp_disp(m_dig[k], sup[k]));
      end
    end
  end

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ocup_cnt, pulse_at, pulses, blanks, nch, prev;
    int t_inc [3];
    logic [11:0] got [2];

    reset = 1'b1; enable = 1'b1; animar = 1'b0; piscar = 1'b0; pontos7 = '0; pontos10 = '0;
    step_cycles(2);
    cmp_on = 1'b1;
    chk("rst_disp", 0, disp_x[0], {7'h7F, 7'h7F, 7'h40});
    chk("rst_disp", 1, disp_x[1], {7'h40, 7'h40, 7'h40});
    chk("rst_bcd", 2, bcd_x[2], 0);
    chk("rst_ocupado", 0, ocup_x, 0);
    reset = 1'b0;

    // Plain conversion of 105: latency, busy length, digits.
    step_cycles(1);
    pontos7 = 7'd105;
    ocup_cnt = 0; pulse_at = -1; pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      step_cycles(1);
      if (ocup_x[0]) ocup_cnt++;
      if (atu_x[0]) begin pulses++; if (pulse_at < 0) pulse_at = i; end
    end
    chk("t1_latency", 0, pulse_at, 10);
    chk("t1_busy_cycles", 0, ocup_cnt, 8);
    chk("t1_pulses", 0, pulses, 1);
    chk("t1_bcd", 0, bcd_x[0], 12'h105);
    chk("t1_disp", 0, disp_x[0], {7'h79, 7'h40, 7'h12});

    // Leading-zero blanking on and off.
    pontos7 = 7'd7;
    step_cycles(15);
    chk("t2_disp_sup", 0, disp_x[0], {7'h7F, 7'h7F, 7'h78});
    chk("t2_disp_nosup", 1, disp_x[1], {7'h40, 7'h40, 7'h78});

    // Count-up animation 0 -> 3, then immediate drop to 1.
    pontos7 = 7'd0;
    step_cycles(15);
    animar = 1'b1;
    pontos7 = 7'd3;
    nch = 0; prev = int'(dut_a.mostrado_q);
    for (int i = 1; i <= 40; i++) begin
      step_cycles(1);
      if (int'(dut_a.mostrado_q) != prev) begin
        if (nch < 3) t_inc[nch] = i;
        nch++;
        prev = int'(dut_a.mostrado_q);
      end
    end
    chk("t3_steps", 0, nch, 3);
    if (nch >= 3) begin
      chk("t3_step_gap1", 0, t_inc[1] - t_inc[0], STEP);
      chk("t3_step_gap2", 0, t_inc[2] - t_inc[1], STEP);
    end
    chk("t3_bcd", 0, bcd_x[0], 12'h003);
    pontos7 = 7'd1;
    step_cycles(1);
    chk("t3_drop", 0, dut_a.mostrado_q, 1);
    step_cycles(15);
    animar = 1'b0;

    // Blink windows, then enable off.
    piscar = 1'b1;
    blanks = 0;
    for (int i = 0; i < 20; i++) begin
      step_cycles(1);
      if (disp_x[0] == 21'h1FFFFF) blanks++;
    end
    chk("t4_blank_cycles", 0, blanks, 10);
    piscar = 1'b0;
    step_cycles(1);
    enable = 1'b0;
    #1;
    chk("t4_enable_off", 0, disp_x[0], 21'h1FFFFF);
    chk("t4_digits_kept", 0, bcd_x[0], 12'h001);
    step_cycles(2);
    enable = 1'b1;

    // Value change in the middle of a conversion.
    pontos7 = 7'd50;
    for (int i = 0; i < 10 && !ocup_x[0]; i++) step_cycles(1);
    chk("t5_started", 0, ocup_x[0], 1);
    step_cycles(2);
    pontos7 = 7'd60;
    pulses = 0; got[0] = '0; got[1] = '0;
    for (int i = 0; i < 40; i++) begin
      step_cycles(1);
      if (atu_x[0]) begin
        if (pulses < 2) got[pulses] = bcd_x[0];
        pulses++;
      end
    end
    chk("t5_pulses", 0, pulses, 2);
    chk("t5_first", 0, got[0], 12'h050);
    chk("t5_second", 0, got[1], 12'h060);

    // Saturation on W=10, then reset during a conversion.
    pontos10 = 10'd1000;
    pulses = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) begin
      step_cycles(1);
      if (atu_x[2]) pulses++;
    end
    chk("t6_pulse", 2, pulses, 1);
    chk("t6_bcd_sat", 2, bcd_x[2], 12'h999);
    chk("t6_disp_sat", 2, disp_x[2], {7'h10, 7'h10, 7'h10});
    step_cycles(1);
    pontos10 = 10'd12;
    for (int i = 0; i < 10 && !ocup_x[2]; i++) step_cycles(1);
    step_cycles(3);
    chk("t6_busy_before_rst", 2, ocup_x[2], 1);
    reset = 1'b1;
    step_cycles(1);
    chk("t6_rst_bcd", 2, bcd_x[2], 0);
    chk("t6_rst_ocupado", 2, ocup_x[2], 0);
    chk("t6_rst_atualizado", 2, atu_x[2], 0);
    chk("t6_rst_disp", 2, disp_x[2], {7'h7F, 7'h7F, 7'h40});
    chk("t6_rst_mostrado", 2, dut_c.mostrado_q, 0);
    reset = 1'b0;
    step_cycles(20);
    chk("t6_reconvert", 2, bcd_x[2], 12'h012);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
